// File: rtl/agc_controller.sv
// AM receive-chain AGC: tracks windowed envelope peak and steps the IF filter gain,
// with a once-per-window fast attack on envelope saturation.
module agc_controller #(
    parameter int unsigned WINDOW_LOG2  = 12,
    parameter logic [7:0]  HI_THRESH    = 8'd200,
    parameter logic [7:0]  LO_THRESH    = 8'd48,
    parameter int unsigned HOLD_WINDOWS = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] env_in,
    input  logic       agc_en,
    input  logic [1:0] manual_gain,
    output logic [1:0] gain_out,
    output logic [7:0] peak_out,
    output logic       clip,
    output logic       agc_active
);

    localparam int unsigned WIN_W  = WINDOW_LOG2;
    localparam int unsigned HOLD_W = 4;

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_TRACK  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        gain_q, gain_d;
    logic [7:0]        peak_q, peak_d;
    logic              clip_q, clip_d;
    logic              active_q;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [7:0]        peak_acc_q, peak_acc_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              lockout_q, lockout_d;

    logic [7:0]        win_max;
    logic [HOLD_W-1:0] hold_inc;
    logic              win_end;
    logic              fast_attack;

    assign win_max     = (env_in > peak_acc_q) ? env_in : peak_acc_q;
    assign hold_inc    = hold_cnt_q + HOLD_W'(1);
    assign win_end     = &win_cnt_q;
    assign fast_attack = (env_in == 8'hFF) && !lockout_q && (gain_q != 2'd0);

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        peak_d     = peak_q;
        clip_d     = 1'b0;
        win_cnt_d  = win_cnt_q;
        peak_acc_d = peak_acc_q;
        hold_cnt_d = hold_cnt_q;
        lockout_d  = lockout_q;

        case (state_q)
            ST_MANUAL: begin
                gain_d     = manual_gain;
                win_cnt_d  = '0;
                peak_acc_d = '0;
                hold_cnt_d = '0;
                lockout_d  = 1'b0;
                if (agc_en) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!agc_en) begin
                    state_d    = ST_MANUAL;
                    gain_d     = manual_gain;
                    win_cnt_d  = '0;
                    peak_acc_d = '0;
                    hold_cnt_d = '0;
                    lockout_d  = 1'b0;
                end else if (fast_attack) begin
                    // Fast attack restarts the window and discards any window-end evaluation
                    gain_d     = gain_q - 2'd1;
                    clip_d     = 1'b1;
                    lockout_d  = 1'b1;
                    win_cnt_d  = '0;
                    peak_acc_d = '0;
                    hold_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    if (win_end) begin
                        peak_d     = win_max;
                        peak_acc_d = '0;
                        lockout_d  = 1'b0;
                        if (win_max >= HI_THRESH) begin
                            if (gain_q != 2'd0) begin
                                gain_d = gain_q - 2'd1;
                            end
                            hold_cnt_d = '0;
                        end else if (win_max < LO_THRESH) begin
                            if (hold_inc >= HOLD_W'(HOLD_WINDOWS)) begin
                                if (gain_q != 2'd3) begin
                                    gain_d = gain_q + 2'd1;
                                end
                                hold_cnt_d = '0;
                            end else begin
                                hold_cnt_d = hold_inc;
                            end
                        end else begin
                            hold_cnt_d = '0;
                        end
                    end else begin
                        peak_acc_d = win_max;
                    end
                end
            end
            default: begin
                state_d = ST_MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_MANUAL;
            gain_q     <= 2'd0;
            peak_q     <= 8'd0;
            clip_q     <= 1'b0;
            active_q   <= 1'b0;
            win_cnt_q  <= '0;
            peak_acc_q <= 8'd0;
            hold_cnt_q <= '0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            peak_q     <= peak_d;
            clip_q     <= clip_d;
            active_q   <= (state_d == ST_TRACK);
            win_cnt_q  <= win_cnt_d;
            peak_acc_q <= peak_acc_d;
            hold_cnt_q <= hold_cnt_d;
            lockout_q  <= lockout_d;
        end
    end

    assign gain_out   = gain_q;
    assign peak_out   = peak_q;
    assign clip       = clip_q;
    assign agc_active = active_q;

endmodule

// File: doc/agc_controller.md
Name: agc_controller

Overview:
- Automatic gain control loop for the AM receive chain.
- Consumes the 8-bit envelope detector output and measures its peak over fixed windows.
- Drives the 2-bit gain select of the IF low-pass filter, replacing the static SPI gain when AGC is enabled.
- Sits downstream of envelope_detector and feeds the gain input of if_filter, closing the loop.

Parameters:
- WINDOW_LOG2, 12, window length = 2^WINDOW_LOG2 clk cycles (benches use 4).
- HI_THRESH, 8'd200, window peak >= this -> slow attack (gain down).
- LO_THRESH, 8'd48, window peak < this counts as a quiet window.
- HOLD_WINDOWS, 4, consecutive quiet windows required before gain up (range 1..15).

Ports:
- clk  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- env_in  input  8  envelope detector output, sampled every cycle.
- agc_en  input  1  1 = automatic gain, 0 = manual.
- manual_gain  input  2  gain value from the SPI register.
- gain_out  output  2  registered gain select to if_filter; 0 = lowest, 3 = highest.
- peak_out  output  8  peak of the last completed window, registered.
- clip  output  1  one-cycle pulse on each fast-attack event.
- agc_active  output  1  1 while the FSM is in TRACK.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. RST=1 at a clk edge sets:
  - gain_out=0, peak_out=0, clip=0, agc_active=0;
  - FSM=MANUAL;
  - win_cnt=0, peak_acc=0, hold_cnt=0, lockout=0.
- RST asserted mid-window discards all accumulation.
- FSM has two states, MANUAL and TRACK.
- MANUAL:
  - gain_out <= manual_gain every cycle (1-cycle latency).
  - win_cnt, peak_acc, hold_cnt and lockout are held at 0; peak_out holds its value.
  - agc_en=1 -> TRACK on the next edge. gain_out keeps the last manual value as the starting point.
- TRACK:
  - agc_active=1.
  - agc_en=0 -> MANUAL on the next edge. That same edge loads gain_out <= manual_gain and clears the counters.
- Window, in TRACK:
  - win_cnt increments each cycle and wraps at 2^WINDOW_LOG2-1.
  - peak_acc <= max(peak_acc, env_in).
  - Window end is the cycle where win_cnt == 2^WINDOW_LOG2-1. The max includes that cycle's env_in; call the result P.
- At window end, non-fast-attack path (all on the same edge):
  - peak_out <= P; peak_acc <= 0; lockout <= 0.
  - If P >= HI_THRESH: gain_out decrements, saturating at 0; hold_cnt <= 0.
  - Else if P < LO_THRESH: hold_cnt increments. When it reaches HOLD_WINDOWS, gain_out increments (saturating at 3) and hold_cnt <= 0.
  - Else: hold_cnt <= 0, gain unchanged.
- Fast attack, in TRACK:
  - Triggers when env_in == 8'hFF, lockout == 0 and gain_out > 0.
  - Next edge: gain_out decrements, clip pulses 1 for one cycle, lockout <= 1, win_cnt <= 0, peak_acc <= 0, hold_cnt <= 0.
  - peak_out is unchanged.
- Priority: a fast attack in the window-end cycle wins. The window evaluation is discarded and peak_out is not updated.
- env_in=FF with gain_out=0 or lockout=1: no clip and no fast attack; the sample enters peak_acc normally.
- lockout is cleared only at a window end or by leaving TRACK, so at most one fast attack happens per window.
- Gain changes by at most 1 step per cycle. It never wraps: 0 stays 0 on decrement, 3 stays 3 on increment.

Test Plan (WINDOW_LOG2=4, HOLD_WINDOWS=2):
- Reset, then agc_en=0, manual_gain=2 for 3 cycles -> gain_out=2 one cycle after the change; agc_active=0; peak_out=0.
- agc_en=1 from gain 2, env_in constant 220 -> after 16 cycles peak_out=220 and gain_out=1; after 32 cycles gain_out=0; stays 0 thereafter.
- TRACK, gain 1, env_in=20 constant -> first window: hold=1, gain 1; second window end: gain_out=2; continues up to 3 and saturates.
- TRACK, gain 3, single env_in=FF at cycle 5 -> next cycle clip=1 and gain_out=2; window restarts. FF again within the same window -> no clip; at window end peak_out=FF and gain_out=1.
- FF coincident with window-end cycle -> one decrement only; peak_out unchanged.
- TRACK mid-window, drop agc_en with manual_gain=1 -> next cycle gain_out=1, agc_active=0. Separately, assert RST mid-window -> all outputs 0.
